// File: rtl/noise_addr_gen.sv
// Address sequencer for the 4096-entry noise LUT: steps a start address by a
// fixed increment at a divided sample rate, either looping or for a fixed count.
module noise_addr_gen #(
    parameter int ADDR_W = 12,
    parameter int DIV_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_stop,
    input  logic              i_oneshot,
    input  logic [ADDR_W-1:0] i_start_addr,
    input  logic [ADDR_W-1:0] i_step,
    input  logic [ADDR_W-1:0] i_len,
    input  logic [DIV_W-1:0]  i_rate_div,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_addr_vld,
    output logic              o_busy,
    output logic              o_done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [ADDR_W-1:0] step_q, step_nxt;
    logic [ADDR_W-1:0] len_q, len_nxt;
    logic [DIV_W-1:0]  rate_q, rate_nxt;
    logic [DIV_W-1:0]  div_cnt, div_nxt;
    logic [ADDR_W:0]   samp_cnt, samp_nxt;
    logic [ADDR_W:0]   samp_total;
    logic              oneshot_q, oneshot_nxt;
    logic              vld_nxt, busy_nxt, done_nxt;
    logic              tick;

    // Modulo-2^ADDR_W address advance; the carry out is intentionally dropped.
    function automatic logic [ADDR_W-1:0] wrap_add(input logic [ADDR_W-1:0] a,
                                                   input logic [ADDR_W-1:0] b);
        return a + b;
    endfunction

    assign tick       = (div_cnt == rate_q);
    assign samp_total = {1'b0, len_q} + {{ADDR_W{1'b0}}, 1'b1};

    always_comb begin
        state_nxt   = state;
        addr_nxt    = o_addr;
        step_nxt    = step_q;
        len_nxt     = len_q;
        rate_nxt    = rate_q;
        oneshot_nxt = oneshot_q;
        div_nxt     = div_cnt;
        samp_nxt    = samp_cnt;
        vld_nxt     = 1'b0;
        done_nxt    = 1'b0;

        case (state)
            S_IDLE: begin
                if (i_start && !i_stop) begin
                    state_nxt   = S_RUN;
                    oneshot_nxt = i_oneshot;
                    step_nxt    = i_step;
                    len_nxt     = i_len;
                    rate_nxt    = i_rate_div;
                    addr_nxt    = i_start_addr;
                    vld_nxt     = 1'b1;
                    div_nxt     = '0;
                    samp_nxt    = {{ADDR_W{1'b0}}, 1'b1};
                end
            end
            S_RUN: begin
                if (i_stop) begin
                    state_nxt = S_IDLE;
                end else if (tick) begin
                    div_nxt = '0;
                    if (!oneshot_q || (samp_cnt != samp_total)) begin
                        addr_nxt = wrap_add(o_addr, step_q);
                        vld_nxt  = 1'b1;
                        samp_nxt = samp_cnt + 1'b1;
                    end else begin
                        state_nxt = S_DONE;
                        done_nxt  = 1'b1;
                    end
                end else begin
                    div_nxt = div_cnt + 1'b1;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        busy_nxt = (state_nxt != S_IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= S_IDLE;
            o_addr     <= '0;
            o_addr_vld <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            step_q     <= '0;
            len_q      <= '0;
            rate_q     <= '0;
            oneshot_q  <= 1'b0;
            div_cnt    <= '0;
            samp_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            o_addr     <= addr_nxt;
            o_addr_vld <= vld_nxt;
            o_busy     <= busy_nxt;
            o_done     <= done_nxt;
            step_q     <= step_nxt;
            len_q      <= len_nxt;
            rate_q     <= rate_nxt;
            oneshot_q  <= oneshot_nxt;
            div_cnt    <= div_nxt;
            samp_cnt   <= samp_nxt;
        end
    end

endmodule

// File: tb/tb_noise_addr_gen.sv
// Directed bench for noise_addr_gen: cycle-by-cycle vector table plus
// long-running loop-wrap and full-length one-shot sequences.
module tb_noise_addr_gen;

    logic        clk = 1'b0;
    logic        rst, start, stop, oneshot;
    logic [11:0] start_addr, step, len;
    logic [15:0] rate_div;
    logic [11:0] addr;
    logic        addr_vld, busy, done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    noise_addr_gen #(.ADDR_W(12), .DIV_W(16)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_stop      (stop),
        .i_oneshot   (oneshot),
        .i_start_addr(start_addr),
        .i_step      (step),
        .i_len       (len),
        .i_rate_div  (rate_div),
        .o_addr      (addr),
        .o_addr_vld  (addr_vld),
        .o_busy      (busy),
        .o_done      (done)
    );

    typedef struct {
        logic        rst, start, stop, oneshot;
        logic [11:0] sa, st, ln;
        logic [15:0] rate;
        logic [11:0] e_addr;
        logic        e_vld, e_busy, e_done;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input int r, input int s, input int p, input int os,
                                input int sa, input int st, input int ln, input int rate,
                                input int ea, input int ev, input int eb, input int ed);
        vec_t v;
        v.rst = 1'(r); v.start = 1'(s); v.stop = 1'(p); v.oneshot = 1'(os);
        v.sa = 12'(sa); v.st = 12'(st); v.ln = 12'(ln); v.rate = 16'(rate);
        v.e_addr = 12'(ea); v.e_vld = 1'(ev); v.e_busy = 1'(eb); v.e_done = 1'(ed);
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    // Drive inputs on the falling edge, then sample 1 ns after the rising edge.
    task automatic cyc(input logic r, input logic s, input logic p, input logic os,
                       input logic [11:0] sa, input logic [11:0] st,
                       input logic [11:0] ln, input logic [15:0] rate);
        @(negedge clk);
        rst = r; start = s; stop = p; oneshot = os;
        start_addr = sa; step = st; len = ln; rate_div = rate;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cyc();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 12'd0, 12'd0, 12'd0, 16'd0);
    endtask

    int cnt;
    int seen_done;

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; oneshot = 1'b0;
        start_addr = '0; step = '0; len = '0; rate_div = '0;

        //          rst st sp os  sa    step len rate  addr vld busy done
        tbl.push_back(mk(1, 0, 0, 0,    0,   0,  0,  0,    0,  0, 0, 0));
        // one-shot 10,13,16,19 at 3-cycle spacing, garbage inputs while running
        tbl.push_back(mk(0, 1, 0, 1,   10,   3,  3,  2,   10,  1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,  500,   7,  9,  0,   10,  0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,    0,   0,  0,  0,   10,  0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,    0,   0,  0,  0,   13,  1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,    0,   0,  0,  0,   13,  0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,    0,   0,  0,  0,   13,  0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,    0,   0,  0,  0,   16,  1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,    0,   0,  0,  0,   16,  0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,    0,   0,  0,  0,   16,  0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,    0,   0,  0,  0,   19,  1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,    0,   0,  0,  0,   19,  0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,    0,   0,  0,  0,   19,  0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,    0,   0,  0,  0,   19,  0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0,    0,   0,  0,  0,   19,  0, 0, 0));
        // loop from 4, stop at 7 (stop beats the tick), then start+stop in IDLE
        tbl.push_back(mk(0, 1, 0, 0,    4,   1,  0,  0,    4,  1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,    0,   0,  0,  0,    5,  1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,    0,   0,  0,  0,    6,  1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,    0,   0,  0,  0,    7,  1, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0,    0,   0,  0,  0,    7,  0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,    0,   0,  0,  0,    7,  0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0,   99,   1,  0,  0,    7,  0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,    0,   0,  0,  0,    7,  0, 0, 0));
        // wrap 4094 -> 3 -> 8, then reset beats a simultaneous start
        tbl.push_back(mk(0, 1, 0, 0, 4094,   5,  0,  0, 4094,  1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,    0,   0,  0,  0,    3,  1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,    0,   0,  0,  0,    8,  1, 1, 0));
        tbl.push_back(mk(1, 1, 0, 0,   55,   1,  0,  0,    0,  0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,    0,   0,  0,  0,    0,  0, 0, 0));
        // step=0 one-shot, len=1: same address pulsed twice, then DONE
        tbl.push_back(mk(0, 1, 0, 1,  100,   0,  1,  0,  100,  1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,    0,   0,  0,  0,  100,  1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,    0,   0,  0,  0,  100,  0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0,    0,   0,  0,  0,  100,  0, 0, 0));
        // len=0 one-shot, stop while in DONE
        tbl.push_back(mk(0, 1, 0, 1,   50,   2,  0,  0,   50,  1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,    0,   0,  0,  0,   50,  0, 1, 1));
        tbl.push_back(mk(0, 0, 1, 0,    0,   0,  0,  0,   50,  0, 0, 0));
        // reset mid-run, start ignored while running, clean restart
        tbl.push_back(mk(0, 1, 0, 0,   20,   1,  0,  1,   20,  1, 1, 0));
        tbl.push_back(mk(0, 1, 0, 1,  999,   9,  0,  0,   20,  0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,    0,   0,  0,  0,   21,  1, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0,    0,   0,  0,  0,    0,  0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0,   30,   2,  0,  0,   30,  1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,    0,   0,  0,  0,   32,  1, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0,    0,   0,  0,  0,   32,  0, 0, 0));

        foreach (tbl[i]) begin
            cyc(tbl[i].rst, tbl[i].start, tbl[i].stop, tbl[i].oneshot,
                tbl[i].sa, tbl[i].st, tbl[i].ln, tbl[i].rate);
            chk("addr", i, int'(addr),     int'(tbl[i].e_addr));
            chk("vld",  i, int'(addr_vld), int'(tbl[i].e_vld));
            chk("busy", i, int'(busy),     int'(tbl[i].e_busy));
            chk("done", i, int'(done),     int'(tbl[i].e_done));
        end

        // Loop from 0 at full rate: 0..4095 then back to 0.
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 12'd0, 12'd1, 12'd0, 16'd0);
        chk("loop_addr", 0, int'(addr), 0);
        chk("loop_vld",  0, int'(addr_vld), 1);
        for (int i = 1; i <= 4096; i++) begin
            idle_cyc();
            chk("loop_addr", i, int'(addr), i % 4096);
            chk("loop_vld",  i, int'(addr_vld), 1);
        end
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 12'd0, 12'd0, 12'd0, 16'd0);
        chk("loop_stop_busy", 0, int'(busy), 0);

        // Full-length one-shot: exactly 4096 pulses, then o_done.
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 12'd0, 12'd1, 12'd4095, 16'd0);
        cnt = addr_vld ? 1 : 0;
        seen_done = 0;
        for (int i = 0; i < 5000; i++) begin
            idle_cyc();
            if (addr_vld) cnt++;
            if (done) begin
                seen_done = 1;
                break;
            end
        end
        chk("full_pulses", 0, cnt, 4096);
        chk("full_done",   0, seen_done, 1);
        chk("full_last_addr", 0, int'(addr), 4095);
        idle_cyc();
        chk("full_busy_after", 0, int'(busy), 0);
        chk("full_done_after", 0, int'(done), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
